// File: rtl/display_stream_arbiter.sv
// rtl/display_stream_arbiter.sv - band sequencer between rasterizer stream, SPI display controller and TFT bypass
module display_stream_arbiter #(
    parameter int unsigned PIXEL_PER_BAND  = 15360,
    parameter int unsigned BANDS_PER_FRAME = 5,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned PIX_CNT_WIDTH   = 14,
    parameter int unsigned BAND_CNT_WIDTH  = 3
) (
    input  logic                      aclk,
    input  logic                      reset,
    input  logic                      s_fb_axis_tvalid,
    output logic                      s_fb_axis_tready,
    input  logic                      s_fb_axis_tlast,
    input  logic [DATA_WIDTH-1:0]     s_fb_axis_tdata,
    output logic                      m_disp_axis_tvalid,
    input  logic                      m_disp_axis_tready,
    output logic                      m_disp_axis_tlast,
    output logic [DATA_WIDTH-1:0]     m_disp_axis_tdata,
    input  logic                      transfer_running,
    input  logic                      bypass_req,
    output logic                      bypass_grant,
    output logic [BAND_CNT_WIDTH-1:0] band_index,
    output logic                      frame_done,
    output logic                      tlast_error,
    input  logic                      clear_error
);

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, BYPASS} state_t;

    localparam logic [PIX_CNT_WIDTH-1:0]  PIX_LAST  = PIX_CNT_WIDTH'(PIXEL_PER_BAND - 1);
    localparam logic [BAND_CNT_WIDTH-1:0] BAND_LAST = BAND_CNT_WIDTH'(BANDS_PER_FRAME - 1);

    state_t                    state_q, state_d;
    logic [PIX_CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [BAND_CNT_WIDTH-1:0] band_q, band_d;
    logic                      grant_q, grant_d;
    logic                      frame_done_q, frame_done_d;
    logic                      err_q, err_d;
    logic                      prio_q, prio_d;     // 1: bypass wins a tie in IDLE

    logic in_stream;
    logic gen_tlast;
    logic accept;

    assign in_stream = (state_q == STREAM);
    assign gen_tlast = (cnt_q == PIX_LAST);
    assign accept    = in_stream && s_fb_axis_tvalid && m_disp_axis_tready;

    assign m_disp_axis_tvalid = in_stream && s_fb_axis_tvalid;
    assign s_fb_axis_tready   = in_stream && m_disp_axis_tready;
    assign m_disp_axis_tlast  = in_stream && gen_tlast;
    assign m_disp_axis_tdata  = s_fb_axis_tdata;

    assign bypass_grant = grant_q;
    assign band_index   = band_q;
    assign frame_done   = frame_done_q;
    assign tlast_error  = err_q;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        band_d       = band_q;
        prio_d       = prio_q;
        err_d        = err_q;
        frame_done_d = 1'b0;

        // A framing error seen on this beat outranks a simultaneous clear.
        if (clear_error) begin
            err_d = 1'b0;
        end
        if (accept && (s_fb_axis_tlast != gen_tlast)) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (bypass_req && !transfer_running && (prio_q || !s_fb_axis_tvalid)) begin
                    state_d = BYPASS;
                end else if (s_fb_axis_tvalid) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    if (gen_tlast) begin
                        cnt_d   = '0;
                        state_d = DRAIN;
                        if (band_q == BAND_LAST) begin
                            band_d       = '0;
                            frame_done_d = 1'b1;
                        end else begin
                            band_d = band_q + 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Controller must release chip select before anyone else gets the panel.
                if (!transfer_running) begin
                    state_d = IDLE;
                    prio_d  = 1'b1;
                end
            end
            BYPASS: begin
                if (!bypass_req) begin
                    state_d = IDLE;
                    prio_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = (state_d == BYPASS);
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            band_q       <= '0;
            grant_q      <= 1'b0;
            frame_done_q <= 1'b0;
            err_q        <= 1'b0;
            prio_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            band_q       <= band_d;
            grant_q      <= grant_d;
            frame_done_q <= frame_done_d;
            err_q        <= err_d;
            prio_q       <= prio_d;
        end
    end

endmodule
